// File: rtl/button_counter_pkg.sv
// ---------------------------------------------------------------------------
// button_counter_pkg
// Shared definitions for the debounced up/down LED counter:
//   - default parameter values (width, debounce length, repeat timing)
//   - rpt_state_t : per-channel auto-repeat FSM state
//   - action_t    : counter action selected in a given cycle
//   - decode_action() : resolves the per-cycle action priority
// ---------------------------------------------------------------------------
package button_counter_pkg;

    localparam int DEF_WIDTH           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 64;
    localparam int DEF_REPEAT_PERIOD   = 16;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_INC  = 2'd1,
        ACT_DEC  = 2'd2,
        ACT_CLR  = 2'd3
    } action_t;

    // Clear beats everything; up and down together cancel each other.
    function automatic action_t decode_action(input logic i_clr,
                                              input logic i_inc,
                                              input logic i_dec);
        action_t v_act;
        if (i_clr) begin
            v_act = ACT_CLR;
        end else if (i_inc && i_dec) begin
            v_act = ACT_NONE;
        end else if (i_inc) begin
            v_act = ACT_INC;
        end else if (i_dec) begin
            v_act = ACT_DEC;
        end else begin
            v_act = ACT_NONE;
        end
        return v_act;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, counting debouncer and rising-edge detector for one
// raw push-button.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_btn      : raw asynchronous button (active-high)
//   o_level    : debounced button level
//   o_press    : one-cycle pulse, registered together with the 0->1 flip of
//                o_level, so the consumer sees it in the following cycle
// ---------------------------------------------------------------------------
module btn_debounce
    import button_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Synchronise, count consecutive differing samples, flip level on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt   <= CNT_ZERO;
                r_press <= 1'b0;
            end else if (r_cnt == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th differing sample: accept it.
                r_level <= r_sync2;
                r_cnt   <= CNT_ZERO;
                r_press <= r_sync2;
            end else begin
                r_cnt   <= r_cnt + CNT_ONE;
                r_press <= 1'b0;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/debounced_updown_counter.sv
// ---------------------------------------------------------------------------
// debounced_updown_counter
// Up/down LED counter driven by three raw push-buttons (up, down, clear).
// Each button is synchronised, debounced and edge-detected; the resulting
// press pulses step a registered counter in wrap or saturate mode.
// Optional feature macro: AUTO_REPEAT_EN -- holding up/down auto-repeats
// after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
// Ports:
//   clk, rst_n                  : system clock, asynchronous active-low reset
//   btn_up, btn_down, btn_clr   : raw asynchronous active-high buttons
//   count [WIDTH-1:0]           : registered counter value
//   ovf, unf                    : one-cycle registered overflow/underflow pulses
// ---------------------------------------------------------------------------
module debounced_updown_counter
    import button_counter_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SATURATE        = 0,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic    w_up_lvl,  w_up_press;
    logic    w_dn_lvl,  w_dn_press;
    logic    w_clr_lvl, w_clr_press;
    logic    w_up_step, w_dn_step;
    action_t w_action;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_up),
        .o_level(w_up_lvl), .o_press(w_up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_down),
        .o_level(w_dn_lvl), .o_press(w_dn_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_clr),
        .o_level(w_clr_lvl), .o_press(w_clr_press)
    );

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW     = $clog2(RPT_MAX + 1);
    localparam logic [RCW-1:0] RPT_ZERO     = {RCW{1'b0}};
    localparam logic [RCW-1:0] RPT_ONE      = {{(RCW-1){1'b0}}, 1'b1};
    localparam logic [RCW-1:0] RPT_DLY_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RPT_PER_LAST = RCW'(REPEAT_PERIOD - 1);

    // Channel 0 = up, channel 1 = down.
    logic [1:0]     w_lvl;
    logic [1:0]     w_press;
    rpt_state_t     r_rpt_state   [2];
    logic [RCW-1:0] r_rpt_cnt     [2];
    rpt_state_t     w_rpt_state_nxt [2];
    logic [RCW-1:0] w_rpt_cnt_nxt [2];
    logic [1:0]     w_rpt_step;

    assign w_lvl   = {w_dn_lvl, w_up_lvl};
    assign w_press = {w_dn_press, w_up_press};

    // Repeat FSM state and interval counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                r_rpt_state[ch] <= RPT_IDLE;
                r_rpt_cnt[ch]   <= RPT_ZERO;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                r_rpt_state[ch] <= w_rpt_state_nxt[ch];
                r_rpt_cnt[ch]   <= w_rpt_cnt_nxt[ch];
            end
        end
    end

    // Repeat FSM next state; a release or a clear press always returns to idle.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            w_rpt_state_nxt[ch] = r_rpt_state[ch];
            w_rpt_cnt_nxt[ch]   = r_rpt_cnt[ch];
            w_rpt_step[ch]      = 1'b0;
            if (w_clr_press || !w_lvl[ch]) begin
                w_rpt_state_nxt[ch] = RPT_IDLE;
                w_rpt_cnt_nxt[ch]   = RPT_ZERO;
            end else begin
                case (r_rpt_state[ch])
                    RPT_IDLE: begin
                        if (w_press[ch]) begin
                            w_rpt_state_nxt[ch] = RPT_DELAY;
                            w_rpt_cnt_nxt[ch]   = RPT_ZERO;
                        end else begin
                            w_rpt_state_nxt[ch] = RPT_IDLE;
                        end
                    end
                    RPT_DELAY: begin
                        if (r_rpt_cnt[ch] == RPT_DLY_LAST) begin
                            w_rpt_state_nxt[ch] = RPT_REPEAT;
                            w_rpt_cnt_nxt[ch]   = RPT_ZERO;
                            w_rpt_step[ch]      = 1'b1;
                        end else begin
                            w_rpt_cnt_nxt[ch]   = r_rpt_cnt[ch] + RPT_ONE;
                        end
                    end
                    RPT_REPEAT: begin
                        if (r_rpt_cnt[ch] == RPT_PER_LAST) begin
                            w_rpt_cnt_nxt[ch]   = RPT_ZERO;
                            w_rpt_step[ch]      = 1'b1;
                        end else begin
                            w_rpt_cnt_nxt[ch]   = r_rpt_cnt[ch] + RPT_ONE;
                        end
                    end
                    default: begin
                        w_rpt_state_nxt[ch] = RPT_IDLE;
                        w_rpt_cnt_nxt[ch]   = RPT_ZERO;
                    end
                endcase
            end
        end
    end

    // Repeat steps are muted while both direction buttons are held.
    assign w_up_step = w_up_press | (w_rpt_step[0] & ~(w_up_lvl & w_dn_lvl));
    assign w_dn_step = w_dn_press | (w_rpt_step[1] & ~(w_up_lvl & w_dn_lvl));
`else
    assign w_up_step = w_up_press;
    assign w_dn_step = w_dn_press;
`endif

    // Resolve the counter action for this cycle.
    always_comb begin
        w_action = decode_action(w_clr_press, w_up_step, w_dn_step);
    end

    // Counter and flag registers; flags are single-cycle by default clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= CNT_ZERO;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            unf <= 1'b0;
            case (w_action)
                ACT_CLR: count <= CNT_ZERO;
                ACT_INC: begin
                    if (count == CNT_MAX) begin
                        ovf   <= 1'b1;
                        count <= (SATURATE != 0) ? CNT_MAX : CNT_ZERO;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end
                ACT_DEC: begin
                    if (count == CNT_ZERO) begin
                        unf   <= 1'b1;
                        count <= (SATURATE != 0) ? CNT_ZERO : CNT_MAX;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: count <= count;
            endcase
        end
    end

    // The clear level itself is only needed through its press pulse.
    logic w_unused;
    assign w_unused = w_clr_lvl;

endmodule

// File: tb/tb_debounced_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_debounced_updown_counter
// Drives a wrapping (SATURATE=0) and a saturating (SATURATE=1) counter from
// the same buttons. A reference model predicts every output change from the
// raw button samples (window rule: a level flips once the last
// DEBOUNCE_CYCLES synchronised samples all differ from it; a rising flip
// steps the counter one edge later) and queues it; a monitor pops an entry
// whenever a DUT output changes and compares value and edge number.
// ---------------------------------------------------------------------------
module tb_debounced_updown_counter;

    localparam int W    = 4;
    localparam int N    = 16;
    localparam int MAXC = 20000;
    localparam int CMAX = (1 << W) - 1;
`ifdef AUTO_REPEAT_EN
    localparam int RD = 64;
    localparam int RP = 16;
`endif

    typedef struct packed {
        int   cyc;
        int   cnt;
        logic ovf;
        logic unf;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         b_up, b_dn, b_clr;
    logic [W-1:0] cnt_w, cnt_s;
    logic         ovf_w, unf_w, ovf_s, unf_s;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    debounced_updown_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(N), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .btn_up(b_up), .btn_down(b_dn), .btn_clr(b_clr),
        .count(cnt_w), .ovf(ovf_w), .unf(unf_w)
    );

    debounced_updown_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(N), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .btn_up(b_up), .btn_down(b_dn), .btn_clr(b_clr),
        .count(cnt_s), .ovf(ovf_s), .unf(unf_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit  raw [3][MAXC];
    bit  lvl [3];
    bit  rose[3];
    int  k0 = 0;
    int  exp_c[2];
    bit  exp_o[2], exp_u[2];
    ev_t last_e[2];
    ev_t q0[$], q1[$];
`ifdef AUTO_REPEAT_EN
    bit rpt_on[2];
    int rpt_t0[2];
`endif

    function automatic bit samp(input int b, input int e);
        if (e - 2 >= k0) return raw[b][e-2];
        return 1'b0;
    endfunction

    function automatic bit flips(input int b, input int k);
        for (int j = 0; j < N; j++) begin
            if (k - j < k0) return 1'b0;
            if (samp(b, k - j) == lvl[b]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic apply(input int i, input bit inc, input bit dec, input bit clr);
        exp_o[i] = 1'b0;
        exp_u[i] = 1'b0;
        if (clr) begin
            exp_c[i] = 0;
        end else if (inc && dec) begin
            exp_c[i] = exp_c[i];
        end else if (inc) begin
            if (exp_c[i] == CMAX) begin
                exp_o[i] = 1'b1;
                exp_c[i] = (i == 1) ? CMAX : 0;
            end else exp_c[i] = exp_c[i] + 1;
        end else if (dec) begin
            if (exp_c[i] == 0) begin
                exp_u[i] = 1'b1;
                exp_c[i] = (i == 1) ? 0 : CMAX;
            end else exp_c[i] = exp_c[i] - 1;
        end
    endtask

    always @(posedge clk) begin
        bit su, sd, sc;
        ev_t e;
        cyc++;
        if (cyc < MAXC) begin
            if (!rst_n) begin
                k0 = cyc + 1;
                for (int b = 0; b < 3; b++) begin lvl[b] = 1'b0; rose[b] = 1'b0; end
                for (int i = 0; i < 2; i++) begin exp_c[i] = 0; exp_o[i] = 1'b0; exp_u[i] = 1'b0; end
`ifdef AUTO_REPEAT_EN
                rpt_on[0] = 1'b0; rpt_on[1] = 1'b0;
`endif
            end else begin
                raw[0][cyc] = b_up; raw[1][cyc] = b_dn; raw[2][cyc] = b_clr;
                su = rose[0]; sd = rose[1]; sc = rose[2];
`ifdef AUTO_REPEAT_EN
                for (int ch = 0; ch < 2; ch++) begin
                    if (rpt_on[ch] && !lvl[ch]) rpt_on[ch] = 1'b0;
                    if (rpt_on[ch] && !(lvl[0] && lvl[1]) && (cyc - rpt_t0[ch] >= RD) &&
                        ((cyc - rpt_t0[ch] - RD) % RP == 0)) begin
                        if (ch == 0) su = 1'b1; else sd = 1'b1;
                    end
                end
                for (int ch = 0; ch < 2; ch++) begin
                    if (sc) rpt_on[ch] = 1'b0;
                    else if (rose[ch]) begin rpt_on[ch] = 1'b1; rpt_t0[ch] = cyc; end
                end
`endif
                for (int i = 0; i < 2; i++) apply(i, su, sd, sc);
                for (int b = 0; b < 3; b++) begin
                    if (flips(b, cyc)) begin
                        lvl[b]  = ~lvl[b];
                        rose[b] = lvl[b];
                    end else rose[b] = 1'b0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                e.cyc = cyc; e.cnt = exp_c[i]; e.ovf = exp_o[i]; e.unf = exp_u[i];
                if (e.cnt != last_e[i].cnt || e.ovf != last_e[i].ovf || e.unf != last_e[i].unf) begin
                    if (i == 0) q0.push_back(e); else q1.push_back(e);
                    last_e[i] = e;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    ev_t last_d[2];

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ev_t qpop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic ev_t qfront(input int i);
        if (i == 0) return q0[0];
        return q1[0];
    endfunction

    always @(posedge clk) begin
        ev_t g, x;
        #1;
        for (int i = 0; i < 2; i++) begin
            g.cyc = cyc;
            g.cnt = (i == 0) ? int'(cnt_w) : int'(cnt_s);
            g.ovf = (i == 0) ? ovf_w : ovf_s;
            g.unf = (i == 0) ? unf_w : unf_s;
            while (qsize(i) > 0 && qfront(i).cyc < cyc) begin
                x = qpop(i);
                n_cmp++; n_bad++;
                $display("FAIL missed_change inst%0d: expected cnt=%0d ovf=%0d unf=%0d at edge %0d, output unchanged",
                         i, x.cnt, x.ovf, x.unf, x.cyc);
            end
            if (g.cnt != last_d[i].cnt || g.ovf != last_d[i].ovf || g.unf != last_d[i].unf) begin
                if (qsize(i) == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_change inst%0d @edge %0d: got cnt=%0d ovf=%0d unf=%0d, expected no change",
                             i, cyc, g.cnt, g.ovf, g.unf);
                end else begin
                    x = qpop(i);
                    chk($sformatf("edge_inst%0d", i), g.cyc, x.cyc);
                    chk($sformatf("count_inst%0d", i), g.cnt, x.cnt);
                    chk($sformatf("ovf_inst%0d", i), int'(g.ovf), int'(x.ovf));
                    chk($sformatf("unf_inst%0d", i), int'(g.unf), int'(x.unf));
                end
                last_d[i] = g;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        {b_clr, b_dn, b_up} = 3'b000;
        repeat (n) @(negedge clk);
    endtask

    // m = {clr, down, up}
    task automatic press(input logic [2:0] m, input int hold, input int gap);
        @(negedge clk);
        {b_clr, b_dn, b_up} = m;
        repeat (hold) @(negedge clk);
        {b_clr, b_dn, b_up} = 3'b000;
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_cnt_w"}, int'(cnt_w), 0);
        chk({nm, "_cnt_s"}, int'(cnt_s), 0);
        chk({nm, "_flags"}, int'({ovf_w, unf_w, ovf_s, unf_s}), 0);
    endtask

    initial begin
        #(10 * MAXC);
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        {b_clr, b_dn, b_up} = 3'b000;
        // Reset with buttons toggling: outputs must stay at zero.
        repeat (12) begin
            @(negedge clk);
            {b_clr, b_dn, b_up} = 3'($urandom_range(7, 0));
            chk_zero("in_reset");
        end
        @(negedge clk);
        {b_clr, b_dn, b_up} = 3'b000;
        rst_n = 1'b1;
        idle(30);
        chk_zero("after_reset");

        // Clean up presses: wrap goes 1..15,0,1..4; saturate stops at 15.
        // Each step lands 19 edges after the first edge sampling the press.
        for (int p = 0; p < 20; p++) press(3'b001, 25, 25);

        // Bouncing contact: 5-cycle highs/lows for 60 cycles, then held 30.
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            b_up = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (5) @(negedge clk);
        end
        b_up = 1'b1;
        repeat (30) @(negedge clk);
        idle(30);

        // Clear, then down at zero (wrap -> 15 with unf, saturate holds with unf).
        press(3'b100, 25, 25);
        press(3'b010, 25, 25);

        // Up and down together: no change; clear and up together: cleared, no ovf.
        press(3'b011, 25, 25);
        press(3'b001, 25, 25);
        press(3'b101, 25, 25);
        press(3'b001, 25, 25);

        // Reset in the middle of an up debounce; still held afterwards.
        @(negedge clk);
        b_up = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("mid_debounce_reset");
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        idle(30);

        // Randomised presses, glitches and gaps.
        for (int t = 0; t < 40; t++) begin
            press(3'($urandom_range(7, 1)), int'($urandom_range(40, 1)), int'($urandom_range(40, 2)));
        end

        idle(60);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debounced_updown_counter.md
Name: debounced_updown_counter

Overview:
Parametrised successor to the single-button LED counter. Counts up/down on debounced, synchronised push-button presses, with a synchronous clear and selectable wrap/saturate mode, all in a proper system clock domain. Sits between the board buttons and the LED bus.

Parameters:
WIDTH, 4, counter/LED width in bits (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a button level change (>=2)
SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at 0 and 2^WIDTH-1
REPEAT_DELAY, 64, hold cycles before auto-repeat starts (used only with AUTO_REPEAT_EN)
REPEAT_PERIOD, 16, cycles between auto-repeat steps (used only with AUTO_REPEAT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_up  input  1  raw asynchronous button, active-high, increment
btn_down  input  1  raw asynchronous button, active-high, decrement
btn_clr  input  1  raw asynchronous button, active-high, clear
count  output  WIDTH  registered counter value (drives LEDs)
ovf  output  1  one-cycle pulse: increment wrapped (SATURATE=0) or was blocked at max (SATURATE=1)
unf  output  1  one-cycle pulse: decrement wrapped (SATURATE=0) or was blocked at 0 (SATURATE=1)

Behaviour:
- Single clock clk; reset asynchronous, active-low (rst_n). While rst_n=0: count=0, ovf=0, unf=0, all synchronisers, debounce counters, debounced levels=0, repeat FSMs in IDLE.
- Each button: 2-flop synchroniser -> debouncer -> rising-edge detector producing a 1-cycle press pulse.
- Debouncer: debounce counter resets whenever synchronised level equals debounced level; counts up while they differ; at DEBOUNCE_CYCLES consecutive differing samples debounced level flips and counter clears. Glitches shorter than DEBOUNCE_CYCLES cycles produce no change.
- Latency: a clean press changes count on the (DEBOUNCE_CYCLES+3)th rising clk edge after the first edge sampling btn high (2 sync + DEBOUNCE_CYCLES + 1 count register). Release produces no count action.
- Priority per cycle: clr pulse > (up and down together) > single up/down. clr: count<=0, no ovf/unf. Up and down pulse together: no change, no flags.
- Up: SATURATE=0: count<=count+1 mod 2^WIDTH; ovf=1 when count was all ones. SATURATE=1: at max, count holds, ovf=1.
- Down: symmetric with unf, at 0.
- ovf/unf registered, asserted in the same cycle count updates, cleared next cycle.
- Holding a button: exactly one step per press unless AUTO_REPEAT_EN.
- rst_n asserted mid-debounce or mid-hold: all state cleared; a button still held after reset release must re-debounce and counts as a new press.

Optional Feature:
AUTO_REPEAT_EN. Defined: up and down each own a repeat FSM IDLE -> DELAY (entered on press pulse, counts REPEAT_DELAY cycles) -> REPEAT (step pulse every REPEAT_PERIOD cycles) ; any state -> IDLE when debounced level drops or clr pulse occurs. Repeat steps obey the same priority, wrap/saturate and ovf/unf rules; while both debounced up and down are high, neither channel repeats. Undefined: no repeat logic, REPEAT_* unused, one step per press.

Decomposition:
- Package button_counter_pkg: default constants (WIDTH, DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD), repeat FSM state typedef (IDLE, DELAY, REPEAT), action typedef (NONE, INC, DEC, CLR).
- Sub-module btn_debounce (sync + debounce + edge detect, parameter DEBOUNCE_CYCLES, outputs level and press pulse), instantiated three times.

Test Plan:
- Reset: rst_n=0 with buttons toggling -> count=0, ovf=unf=0; release rst_n, no presses -> count stays 0.
- WIDTH=4, DEBOUNCE_CYCLES=16, SATURATE=0: 16 clean up presses from 0 -> count 1..15 then 0, ovf pulse only on 15->0, count updates exactly 19 edges after each press.
- Bounce: btn_up toggled with 5-cycle highs/lows for 60 cycles then held 30 cycles -> exactly one increment.
- SATURATE=1: down press at 0 -> count stays 0, unf=1 one cycle; 20 up presses -> count 15, ovf on presses 16-20.
- Simultaneous: up+down pressed on same cycle -> no change; clr+up same cycle -> count=0, no ovf; rst_n pulse during up debounce -> no increment after reset until re-debounced.
- AUTO_REPEAT_EN, REPEAT_DELAY=64, REPEAT_PERIOD=16: hold up 200 cycles after debounce -> one step at press, then steps at +64, +80, +96 ... cycles; release -> stops immediately.
